dht22_responder: RTL
====================

# dht22_responder

Single-wire DHT22 sensor emulator: the responder end of the bus that `DHT22_drive` initiates on. It watches the open-drain `dht22` line for a host start pulse and answers with the standard DHT22 frame: acknowledge, then 40 data bits built from the `hum_i`/`tem_i` inputs plus a checksum. It is used as a board-level stand-in sensor and as the bus model in the `top_dht22` bench, so the real driver can be exercised with known values.

## Interface

**Parameters**
- `US_CYCLES`, default 50: clk cycles per microsecond (50 MHz).
- `T_START_MIN_US`, default 800: minimum host-low width accepted as a start.
- `T_TURN_US`, default 30: delay from host release to the acknowledge.
- `T_ACK_LOW_US`, default 80: acknowledge low time.
- `T_ACK_HIGH_US`, default 80: acknowledge released (high) time.
- `T_BIT_LOW_US`, default 50: low time that precedes every bit.
- `T_ZERO_HIGH_US`, default 26: released time for a 0 bit.
- `T_ONE_HIGH_US`, default 70: released time for a 1 bit.
- `T_END_LOW_US`, default 50: trailing low time after bit 39.

**Ports** (clock and reset first)
- `clk` in 1: system clock.
- `rst` in 1: reset. Asynchronous and active-low.
- `dht22` inout 1: open-drain bus. The block drives only `1'b0` or `1'bz`.
- `hum_i` in 16: humidity word to report.
- `tem_i` in 16: temperature word to report.
- `busy` out 1: high while the block is answering a frame.
- `done` out 1: one-cycle pulse when a frame has completed.
- `err_start` out 1: one-cycle pulse when a host-low pulse was too short to count as a start.
- `frame_cnt` out 8: number of completed frames, wraps modulo 256.

## Operation

**Input path and timing base**
- `dht22` passes through a 2-flop synchronizer to form `line_s`.
- The driver enable `drv_low` is a register. `dht22 = drv_low ? 1'b0 : 1'bz`.
- A 20-bit cycle counter `cnt` clears on every state entry, increments each cycle, and saturates at all-ones.
- Every state limit is `T_x_US*US_CYCLES` cycles.

**State machine**
- IDLE
  - `drv_low` = 0.
  - `line_s` == 0 → HOST_LOW.
- HOST_LOW
  - Measures the host-low width while `line_s` == 0.
  - `line_s` == 1 and `cnt` ≥ `T_START_MIN_US*US_CYCLES`:
    - load `shreg[39:0] = {hum_i, tem_i, csum}`;
    - go to TURN.
  - `line_s` == 1 and `cnt` below the limit: pulse `err_start`, go to IDLE.
- TURN
  - Released for `T_TURN_US`, then → ACK_LOW.
- ACK_LOW
  - Drives low for `T_ACK_LOW_US`, then → ACK_HIGH.
- ACK_HIGH
  - Released for `T_ACK_HIGH_US`.
  - Then → BIT_LOW with `bit_idx` = 0.
- BIT_LOW
  - Drives low for `T_BIT_LOW_US`, then → BIT_HIGH.
- BIT_HIGH
  - Released for `T_ONE_HIGH_US` if `shreg[39]` = 1, or `T_ZERO_HIGH_US` if 0.
  - On exit, shift `shreg` left by 1.
  - `bit_idx` == 39 → END_LOW. Otherwise `bit_idx`+1 → BIT_LOW.
- END_LOW
  - Drives low for `T_END_LOW_US`, then releases and goes to IDLE.
  - On that exit: pulse `done` and increment `frame_cnt`.

**Data and arithmetic**
- `csum = (hum_i[15:8] + hum_i[7:0] + tem_i[15:8] + tem_i[7:0]) mod 256`. It is an 8-bit truncated sum.
- Bits go out MSB first: humidity, then temperature, then checksum.
- `hum_i`/`tem_i` are sampled only at the HOST_LOW→TURN transition. Changes during a frame do not affect it.
- `frame_cnt` wraps 255 → 0.

**Boundary rules**
- Host-low width exactly equal to the limit is accepted.
- A host low that stays down indefinitely is never answered: `cnt` saturates and the block stays in HOST_LOW.
- Bus activity is ignored in every state other than IDLE and HOST_LOW. There is no contention checking.
- Reset asserted mid-frame:
  - `drv_low` clears asynchronously, so the line releases immediately;
  - state returns to IDLE;
  - the partial frame is dropped and `frame_cnt` is cleared.

## Timing

- Reset values: `dht22` = Z, `busy` = 0, `done` = 0, `err_start` = 0, `frame_cnt` = 0.
- Start detect latency: 2 cycles (synchronizer) plus 1 cycle (state register) after the pin edge.
- Durations are exact:
  - each driven-low phase lasts exactly N×`US_CYCLES` cycles of `drv_low` = 1;
  - each released phase lasts N×`US_CYCLES` cycles.
- At 50 MHz:
  - acknowledge: 4000 cycles low, then 4000 released;
  - a 0 bit: 2500 low + 1300 high;
  - a 1 bit: 2500 low + 3500 high.
- `busy` is 1 from TURN entry through the END_LOW exit cycle, and 0 in IDLE and HOST_LOW.
- `done` and `err_start` are registered and last exactly 1 cycle.
- `done` coincides with the cycle in which `drv_low` falls at the end of END_LOW.

## Test plan

1. **Reset:** hold `rst` = 0 → `dht22` = Z, `busy` = 0, `done` = 0, `err_start` = 0, `frame_cnt` = 0.
2. **Nominal frame:** `hum_i` = 16'h0258, `tem_i` = 16'h00FA; host drives low 1 ms, then releases.
   - After 30 µs: 80 µs low, then 80 µs high.
   - Bytes decode as 02 58 00 FA 54 (checksum 0x54).
   - Then a 50 µs end low, a `done` pulse, and `frame_cnt` = 1.
3. **Short start:** host-low of 500 µs → `err_start` pulse; line stays Z; `busy` stays 0.
4. **Checksum wrap and data hold:** `hum_i` = `tem_i` = 16'hFFFF → checksum 0xFC. Changing `hum_i` after the start does not alter the transmitted bits.
5. **Reset mid-frame:** assert `rst` during BIT_LOW of bit 10 → `dht22` = Z in the same cycle, `busy` = 0, `frame_cnt` = 0. A new 1 ms start then produces a complete, correct frame.
6. **Closed loop:** connect to `DHT22_drive` with `hum_i` = 16'h0258, `tem_i` = 16'h00FA → driver `data_out` = 32'h025800FA and `finish` is asserted.

Source files
------------

// File: rtl/dht22_responder_if.sv
// Application-side signals of the DHT22 responder: the reported values and the frame status.
// The open-drain dht22 pin stays a plain inout on the module.
interface dht22_responder_if;
   logic [15:0] hum_i;
   logic [15:0] tem_i;
   logic        busy;
   logic        done;
   logic        err_start;
   logic [7:0]  frame_cnt;

   modport master (
      output hum_i, tem_i,
      input  busy, done, err_start, frame_cnt
   );

   modport slave (
      input  hum_i, tem_i,
      output busy, done, err_start, frame_cnt
   );
endinterface

// File: rtl/dht22_responder.sv
// DHT22 sensor emulator: detects a host start pulse on the open-drain line and answers with
// the acknowledge plus a 40-bit frame {hum, tem, checksum}, MSB first.
module dht22_responder #(
   parameter int unsigned US_CYCLES      = 50,
   parameter int unsigned T_START_MIN_US = 800,
   parameter int unsigned T_TURN_US      = 30,
   parameter int unsigned T_ACK_LOW_US   = 80,
   parameter int unsigned T_ACK_HIGH_US  = 80,
   parameter int unsigned T_BIT_LOW_US   = 50,
   parameter int unsigned T_ZERO_HIGH_US = 26,
   parameter int unsigned T_ONE_HIGH_US  = 70,
   parameter int unsigned T_END_LOW_US   = 50
) (
   input  logic              clk,
   input  logic              rst,
   inout  wire               dht22,
   dht22_responder_if.slave  bus
);

   // Each phase exits on the cycle where cnt reaches its length minus one, so phases are exact.
   // For the start width, the IDLE cycle that first saw the low also counts.
   localparam logic [19:0] StartLim    = 20'(T_START_MIN_US * US_CYCLES - 1);
   localparam logic [19:0] TurnLim     = 20'(T_TURN_US * US_CYCLES - 1);
   localparam logic [19:0] AckLowLim   = 20'(T_ACK_LOW_US * US_CYCLES - 1);
   localparam logic [19:0] AckHighLim  = 20'(T_ACK_HIGH_US * US_CYCLES - 1);
   localparam logic [19:0] BitLowLim   = 20'(T_BIT_LOW_US * US_CYCLES - 1);
   localparam logic [19:0] ZeroHighLim = 20'(T_ZERO_HIGH_US * US_CYCLES - 1);
   localparam logic [19:0] OneHighLim  = 20'(T_ONE_HIGH_US * US_CYCLES - 1);
   localparam logic [19:0] EndLowLim   = 20'(T_END_LOW_US * US_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StHostLow,
      StTurn,
      StAckLow,
      StAckHigh,
      StBitLow,
      StBitHigh,
      StEndLow
   } state_e;

   state_e      state_q;
   logic [1:0]  sync_q;
   logic        line_s;
   logic [19:0] cnt_q;
   logic        drv_low_q;
   logic [39:0] shreg_q;
   logic [5:0]  bit_idx_q;
   logic        busy_q;
   logic        done_q;
   logic        err_start_q;
   logic [7:0]  frame_cnt_q;
   logic [7:0]  csum;
   logic [19:0] high_lim;

   assign dht22  = drv_low_q ? 1'b0 : 1'bz;
   assign line_s = sync_q[1];

   assign csum     = bus.hum_i[15:8] + bus.hum_i[7:0] + bus.tem_i[15:8] + bus.tem_i[7:0];
   assign high_lim = shreg_q[39] ? OneHighLim : ZeroHighLim;

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err_start = err_start_q;
   assign bus.frame_cnt = frame_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         sync_q      <= 2'b11;
         cnt_q       <= '0;
         drv_low_q   <= 1'b0;
         shreg_q     <= '0;
         bit_idx_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_start_q <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         sync_q      <= {sync_q[0], dht22};
         done_q      <= 1'b0;
         err_start_q <= 1'b0;
         if (cnt_q != '1) begin
            cnt_q <= cnt_q + 20'd1;
         end
         unique case (state_q)
            StIdle: begin
               if (!line_s) begin
                  state_q <= StHostLow;
                  cnt_q   <= '0;
               end
            end
            StHostLow: begin
               if (line_s) begin
                  cnt_q <= '0;
                  if (cnt_q >= StartLim) begin
                     shreg_q <= {bus.hum_i, bus.tem_i, csum};
                     busy_q  <= 1'b1;
                     state_q <= StTurn;
                  end else begin
                     err_start_q <= 1'b1;
                     state_q     <= StIdle;
                  end
               end
            end
            StTurn: begin
               if (cnt_q == TurnLim) begin
                  drv_low_q <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= StAckLow;
               end
            end
            StAckLow: begin
               if (cnt_q == AckLowLim) begin
                  drv_low_q <= 1'b0;
                  cnt_q     <= '0;
                  state_q   <= StAckHigh;
               end
            end
            StAckHigh: begin
               if (cnt_q == AckHighLim) begin
                  drv_low_q <= 1'b1;
                  bit_idx_q <= '0;
                  cnt_q     <= '0;
                  state_q   <= StBitLow;
               end
            end
            StBitLow: begin
               if (cnt_q == BitLowLim) begin
                  drv_low_q <= 1'b0;
                  cnt_q     <= '0;
                  state_q   <= StBitHigh;
               end
            end
            StBitHigh: begin
               if (cnt_q == high_lim) begin
                  shreg_q   <= {shreg_q[38:0], 1'b0};
                  drv_low_q <= 1'b1;
                  cnt_q     <= '0;
                  if (bit_idx_q == 6'd39) begin
                     state_q <= StEndLow;
                  end else begin
                     bit_idx_q <= bit_idx_q + 6'd1;
                     state_q   <= StBitLow;
                  end
               end
            end
            StEndLow: begin
               if (cnt_q == EndLowLim) begin
                  drv_low_q   <= 1'b0;
                  done_q      <= 1'b1;
                  busy_q      <= 1'b0;
                  frame_cnt_q <= frame_cnt_q + 8'd1;
                  cnt_q       <= '0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
